// File: rtl/chess_pkg.sv
// Shared definitions for the chess front-end control path.
//   - piece codes: EMPTY, W_PAWN..W_KING (1..6), B_PAWN..B_KING (7..C), MARK (D)
//   - is_white / is_black / owns_piece colour helpers
//   - square_t: 6-bit square {row[2:0], col[2:0]}
//   - state_t: move_controller FSM states
package chess_pkg;

  localparam logic [3:0] EMPTY    = 4'h0;
  localparam logic [3:0] W_PAWN   = 4'h1;
  localparam logic [3:0] W_KNIGHT = 4'h2;
  localparam logic [3:0] W_BISHOP = 4'h3;
  localparam logic [3:0] W_ROOK   = 4'h4;
  localparam logic [3:0] W_QUEEN  = 4'h5;
  localparam logic [3:0] W_KING   = 4'h6;
  localparam logic [3:0] B_PAWN   = 4'h7;
  localparam logic [3:0] B_KNIGHT = 4'h8;
  localparam logic [3:0] B_BISHOP = 4'h9;
  localparam logic [3:0] B_ROOK   = 4'hA;
  localparam logic [3:0] B_QUEEN  = 4'hB;
  localparam logic [3:0] B_KING   = 4'hC;
  localparam logic [3:0] MARK     = 4'hD;

  typedef logic [5:0] square_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOK,
    PICK,
    HOLD,
    CHECK,
    PLACE
  } state_t;

  function automatic logic is_white(input logic [3:0] code);
    return (code >= W_PAWN) && (code <= W_KING);
  endfunction

  function automatic logic is_black(input logic [3:0] code);
    return (code >= B_PAWN) && (code <= B_KING);
  endfunction

  // side: 0 = white, 1 = black
  function automatic logic owns_piece(input logic [3:0] code, input logic side);
    return side ? is_black(code) : is_white(code);
  endfunction

endpackage

// File: rtl/move_controller_if.sv
// Bundle between move_controller and its surroundings (mouse + chess_board).
//   mouse side : xpos, ypos, left, right
//   board side : figure_code, possible_moves in; figure_xy, figure_position,
//                pick_piece, place_piece out
//   status     : turn, holding, move_count
// modport master: the controller; modport slave: the environment.
interface move_controller_if;
  import chess_pkg::*;

  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        right;
  logic [3:0]  figure_code;
  logic [63:0] possible_moves;
  square_t     figure_xy;
  square_t     figure_position;
  logic        pick_piece;
  logic        place_piece;
  logic        turn;
  logic        holding;
  logic [9:0]  move_count;

  modport master (
    input  xpos, ypos, left, right, figure_code, possible_moves,
    output figure_xy, figure_position, pick_piece, place_piece,
           turn, holding, move_count
  );

  modport slave (
    output xpos, ypos, left, right, figure_code, possible_moves,
    input  figure_xy, figure_position, pick_piece, place_piece,
           turn, holding, move_count
  );
endinterface

// File: rtl/pixel_to_square.sv
// Registered pixel -> board square decode (one cycle).
//   clk, rst       : clock, asynchronous active-high reset
//   xpos, ypos     : mouse pixel position
//   sq             : {row, col} under the cursor
//   sq_valid       : cursor lies on the 8x8 board
// Row/col come from seven threshold compares per axis; the number of
// thresholds passed is the index, so no divider is needed.
module pixel_to_square
  import chess_pkg::*;
#(
  parameter int BOARD_X0 = 160,
  parameter int BOARD_Y0 = 60,
  parameter int SQ_SIZE  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output square_t     sq,
  output logic        sq_valid
);

  logic [6:0] x_ge;
  logic [6:0] y_ge;
  logic [2:0] col;
  logic [2:0] row;
  logic       on_board;

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_thr
      assign x_ge[gi] = xpos >= 12'(BOARD_X0 + (gi + 1) * SQ_SIZE);
      assign y_ge[gi] = ypos >= 12'(BOARD_Y0 + (gi + 1) * SQ_SIZE);
    end
  endgenerate

  // Thresholds are monotonic, so the compare vector is a thermometer code.
  assign col = 3'($countones(x_ge));
  assign row = 3'($countones(y_ge));

  assign on_board = (xpos >= 12'(BOARD_X0)) && (xpos < 12'(BOARD_X0 + 8 * SQ_SIZE)) &&
                    (ypos >= 12'(BOARD_Y0)) && (ypos < 12'(BOARD_Y0 + 8 * SQ_SIZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq       <= '0;
      sq_valid <= 1'b0;
    end else begin
      sq       <= {row, col};
      sq_valid <= on_board;
    end
  end

endmodule

// File: rtl/move_controller.sv
// Mouse-driven move controller in front of chess_board.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : move_controller_if.master (mouse in, board query/pulses out,
//              turn / holding / move_count status)
// Optional macro MOVE_CHECK_EN: when defined, a placement needs the target's
// possible_moves bit set and no own piece on it (one extra CHECK cycle).
module move_controller
  import chess_pkg::*;
#(
  parameter int BOARD_X0 = 160,
  parameter int BOARD_Y0 = 60,
  parameter int SQ_SIZE  = 60
) (
  input  logic               clk,
  input  logic               rst,
  move_controller_if.master  bus
);

  square_t    sq;
  logic       sq_valid;
  logic [2:0] l_sync;
  logic [2:0] r_sync;
  logic       l_edge;
  logic       r_edge;

  state_t     state_reg, state_next;
  square_t    cand_reg, cand_next;
  square_t    origin_reg, origin_next;
  square_t    target_reg, target_next;
  logic       commit_reg, commit_next;
  logic       holding_reg, holding_next;
  logic       turn_reg, turn_next;
  logic [9:0] count_reg, count_next;

  pixel_to_square #(
    .BOARD_X0 (BOARD_X0),
    .BOARD_Y0 (BOARD_Y0),
    .SQ_SIZE  (SQ_SIZE)
  ) u_decode (
    .clk      (clk),
    .rst      (rst),
    .xpos     (bus.xpos),
    .ypos     (bus.ypos),
    .sq       (sq),
    .sq_valid (sq_valid)
  );

  // Two sync flops, third flop holds the previous synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_sync <= '0;
      r_sync <= '0;
    end else begin
      l_sync <= {l_sync[1:0], bus.left};
      r_sync <= {r_sync[1:0], bus.right};
    end
  end

  assign l_edge = l_sync[1] & ~l_sync[2];
  assign r_edge = r_sync[1] & ~r_sync[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cand_reg    <= '0;
      origin_reg  <= '0;
      target_reg  <= '0;
      commit_reg  <= 1'b0;
      holding_reg <= 1'b0;
      turn_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      origin_reg  <= origin_next;
      target_reg  <= target_next;
      commit_reg  <= commit_next;
      holding_reg <= holding_next;
      turn_reg    <= turn_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    origin_next  = origin_reg;
    target_next  = target_reg;
    commit_next  = commit_reg;
    holding_next = holding_reg;
    turn_next    = turn_reg;
    count_next   = count_reg;

    case (state_reg)
      IDLE: begin
        if (l_edge && sq_valid) begin
          cand_next  = sq;
          state_next = LOOK;
        end
      end
      // figure_code now reflects the square latched in IDLE.
      LOOK: state_next = owns_piece(bus.figure_code, turn_reg) ? PICK : IDLE;
      PICK: begin
        origin_next  = cand_reg;
        holding_next = 1'b1;
        state_next   = HOLD;
      end
      HOLD: begin
        // Cancel (right click or click on origin) beats everything else.
        if (r_edge || (l_edge && sq_valid && sq == origin_reg)) begin
          target_next = origin_reg;
          commit_next = 1'b0;
          state_next  = PLACE;
        end else if (l_edge && sq_valid) begin
`ifdef MOVE_CHECK_EN
          cand_next   = sq;
          state_next  = CHECK;
`else
          target_next = sq;
          commit_next = 1'b1;
          state_next  = PLACE;
`endif
        end
      end
`ifdef MOVE_CHECK_EN
      CHECK: begin
        if (bus.possible_moves[6'd63 - cand_reg] && !owns_piece(bus.figure_code, turn_reg)) begin
          target_next = cand_reg;
          commit_next = 1'b1;
          state_next  = PLACE;
        end else begin
          state_next  = HOLD;
        end
      end
`endif
      PLACE: begin
        holding_next = 1'b0;
        if (commit_reg) begin
          turn_next   = ~turn_reg;
          if (count_reg != 10'd1023) count_next = count_reg + 10'd1;
          commit_next = 1'b0;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulses are decoded straight from the state register so an async reset
  // clears them immediately.
  assign bus.pick_piece      = (state_reg == PICK);
  assign bus.place_piece     = (state_reg == PLACE);
  assign bus.figure_position = (state_reg == PICK)  ? cand_reg :
                               (state_reg == PLACE) ? target_reg : '0;
  assign bus.figure_xy       = sq;
  assign bus.turn            = turn_reg;
  assign bus.holding         = holding_reg;
  assign bus.move_count      = count_reg;

endmodule
